// File: rtl/param_delay_engine.sv
// param_delay_engine: parametrised mono delay/echo core over an external circular sample buffer
// Ports: Clk, Reset_N (async active-low); Enable/Time/Repeats/Mix controls, latched per sample;
//        In_Valid/D_In/In_Ready sample input; Out_Valid/D_Out sample output; Overrun sticky drop flag;
//        Mem_Addr/Mem_Re/Mem_We/Mem_Wdata/Mem_Rdata to a synchronous memory with one-cycle read latency.
module param_delay_engine #(
    parameter int DW         = 24,
    parameter int AW         = 16,
    parameter int TIME_SCALE = 64
) (
    input  logic          Clk,
    input  logic          Reset_N,
    input  logic          Enable,
    input  logic [7:0]    Time,
    input  logic [7:0]    Repeats,
    input  logic [7:0]    Mix,
    input  logic          In_Valid,
    input  logic [DW-1:0] D_In,
    output logic          In_Ready,
    output logic          Out_Valid,
    output logic [DW-1:0] D_Out,
    output logic          Overrun,
    output logic [AW-1:0] Mem_Addr,
    output logic          Mem_Re,
    output logic          Mem_We,
    output logic [DW-1:0] Mem_Wdata,
    input  logic [DW-1:0] Mem_Rdata
);
    localparam int XW = DW + 11;
    localparam logic [AW-1:0] DMAX = '1;
    typedef enum logic [2:0] {CLEAR, IDLE, READ, CALC, WRITE} state_t;
    state_t state, state_nx;
    logic [AW-1:0] wr_ptr, dly;
    logic [DW-1:0] x_q, w_q, w_nx, y_nx;
    logic en_q;
    logic [7:0] time_q, rep_q, mix_q;
    logic [39:0] prod;
    logic signed [XW-1:0] xe, de, re, me, ie, fb;

    // Fits when every bit above the DW-bit sign position matches it.
    function automatic logic [DW-1:0] sat(input logic signed [XW-1:0] v);
        return (&v[XW-1:DW-1] || ~|v[XW-1:DW-1]) ? v[DW-1:0] : {v[XW-1], {(DW-1){~v[XW-1]}}};
    endfunction

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N)
            state <= CLEAR;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            CLEAR:   state_nx = wr_ptr == DMAX ? IDLE : CLEAR;
            IDLE:    state_nx = In_Valid ? READ : IDLE;
            READ:    state_nx = CALC;
            CALC:    state_nx = WRITE;
            default: state_nx = IDLE;
        endcase
    end

    // wr_ptr doubles as the clear address counter; it wraps back to 0 as the clear ends.
    // Mem_We is gated by Reset_N so no write is presented while reset is held.
    always_comb begin
        In_Ready  = state == IDLE;
        Out_Valid = state == WRITE;
        Mem_Re    = state == READ;
        Mem_We    = Reset_N && (state == CLEAR || state == WRITE);
        Mem_Addr  = state == READ ? wr_ptr - dly : wr_ptr;
        Mem_Wdata = state == WRITE ? w_q : '0;
    end

    always_comb begin
        prod = 40'(time_q) * 40'(TIME_SCALE);
        dly  = prod == '0 ? AW'(1) : prod > 40'(DMAX) ? DMAX : prod[AW-1:0];
        xe   = XW'($signed(x_q));
        de   = XW'($signed(Mem_Rdata));
        re   = XW'(rep_q);
        me   = XW'(mix_q);
        ie   = XW'(9'd256 - {1'b0, mix_q});
        fb   = (de * re) >>> 8;
        w_nx = en_q ? sat(xe + fb) : x_q;
        y_nx = en_q ? sat((xe * ie + de * me) >>> 8) : x_q;
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            wr_ptr  <= '0;
            x_q     <= '0;
            w_q     <= '0;
            en_q    <= 1'b0;
            time_q  <= '0;
            rep_q   <= '0;
            mix_q   <= '0;
            D_Out   <= '0;
            Overrun <= 1'b0;
        end else begin
            if (state == CLEAR || state == WRITE)
                wr_ptr <= wr_ptr + AW'(1);
            if (state == IDLE && In_Valid) begin
                x_q    <= D_In;
                en_q   <= Enable;
                time_q <= Time;
                rep_q  <= Repeats;
                mix_q  <= Mix;
            end
            if (state == CALC) begin
                w_q   <= w_nx;
                D_Out <= y_nx;
            end
            if (In_Valid && state != IDLE)
                Overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_param_delay_engine.sv
// tb_param_delay_engine: scoreboard bench for param_delay_engine (AW=4, TIME_SCALE=2)
module tb_param_delay_engine;
    localparam int TS = 2;
    logic clk, rst_n, enable, in_valid, in_ready, out_valid, overrun, mem_re, mem_we;
    logic [7:0] tm, repeats, mix;
    logic [23:0] d_in, d_out, mem_wdata, mem_rdata, xv;
    logic [3:0] mem_addr;
    logic [23:0] mem [16];
    typedef struct {
        logic [3:0]  ra;
        logic [3:0]  wa;
        logic [23:0] w;
        logic [23:0] y;
    } exp_t;
    exp_t sb[$];
    longint mmem [16];
    int mptr, checks, failures;
    bit mon_en, rd_seen;

    param_delay_engine #(.DW(24), .AW(4), .TIME_SCALE(TS)) dut (
        .Clk(clk), .Reset_N(rst_n), .Enable(enable), .Time(tm), .Repeats(repeats), .Mix(mix),
        .In_Valid(in_valid), .D_In(d_in), .In_Ready(in_ready), .Out_Valid(out_valid), .D_Out(d_out),
        .Overrun(overrun), .Mem_Addr(mem_addr), .Mem_Re(mem_re), .Mem_We(mem_we),
        .Mem_Wdata(mem_wdata), .Mem_Rdata(mem_rdata)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic longint sat(input longint v);
        return v > 8388607 ? 8388607 : v < -8388608 ? -8388608 : v;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_re) begin
                chk("re_we_excl", 64'(mem_we), 0);
                if (sb.size() == 0)
                    chk("rd_unexpected", 64'(mem_re), 0);
                else begin
                    chk("rd_once", 64'(rd_seen), 0);
                    chk("rd_addr", 64'(mem_addr), 64'(sb[0].ra));
                    rd_seen = 1;
                end
            end
            if (mem_we) begin
                if (sb.size() == 0)
                    chk("wr_unexpected", 64'(mem_we), 0);
                else begin
                    chk("rd_before_wr", 64'(rd_seen), 1);
                    chk("wr_addr", 64'(mem_addr), 64'(sb[0].wa));
                    chk("wr_data", 64'(mem_wdata), 64'(sb[0].w));
                    chk("out_valid", 64'(out_valid), 1);
                    chk("d_out", 64'(d_out), 64'(sb[0].y));
                    rd_seen = 0;
                    void'(sb.pop_front());
                end
            end else if (out_valid)
                chk("ov_without_we", 64'(mem_we), 1);
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mmem[i] = 0;
        mptr = 0;
        sb.delete();
        rd_seen = 0;
    endtask

    task automatic send(input logic [23:0] x, input bit en, input logic [7:0] t,
                        input logic [7:0] rp, input logic [7:0] mx);
        longint xs, ds, r, m, w, y;
        int dly, ra, n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 40);
        chk("ready", 64'(in_ready), 1);
        dly = int'(t) * TS;
        if (dly < 1) dly = 1;
        if (dly > 15) dly = 15;
        ra = (mptr - dly) & 15;
        xs = longint'($signed(x));
        ds = mmem[ra];
        r = rp;
        m = mx;
        w = en ? sat(xs + ((ds * r) >>> 8)) : xs;
        y = en ? sat((xs * (256 - m) + ds * m) >>> 8) : xs;
        mmem[mptr] = w;
        sb.push_back('{4'(ra), 4'(mptr), 24'(w), 24'(y)});
        mptr = (mptr + 1) & 15;
        d_in = x; enable = en; tm = t; repeats = rp; mix = mx; in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
        d_in = 24'($urandom); enable = 1'($urandom); tm = 8'($urandom);
        repeats = 8'($urandom); mix = 8'($urandom);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 8);
        chk("latency", 64'(n), 3);
    endtask

    task automatic check_clear(input bit pulse);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("clr_we", 64'(mem_we), 1);
            chk("clr_addr", 64'(mem_addr), 64'(i));
            chk("clr_wdata", 64'(mem_wdata), 0);
            chk("clr_ready", 64'(in_ready), 0);
            in_valid = pulse && i == 5;
        end
        @(negedge clk);
        chk("clr_done_ready", 64'(in_ready), 1);
        chk("clr_done_we", 64'(mem_we), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0; enable = 0; tm = 0; repeats = 0; mix = 0; in_valid = 0; d_in = 0;
        checks = 0; failures = 0; mon_en = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({in_ready, out_valid, d_out, overrun, mem_addr, mem_re, mem_we, mem_wdata}), 0);
        @(posedge clk);
        #1 rst_n = 1;
        check_clear(0);
        mon_en = 1;
        for (int i = 0; i < 12; i++) begin
            send(i == 0 ? 24'd1000 : 24'd0, 1, 3, 0, 128);
            chk("impulse", 64'(d_out), (i == 0 || i == 6) ? 500 : 0);
        end
        for (int i = 0; i < 20; i++) begin
            send(i == 0 ? 24'd1000 : 24'd0, 1, 3, 128, 255);
            if (i == 6) chk("echo1", 64'(d_out), 996);
            if (i == 12) chk("echo2", 64'(d_out), 498);
            if (i == 18) chk("echo3", 64'(d_out), 249);
        end
        send(24'h7FFFF0, 1, 0, 0, 0);
        send(24'h7FFFF0, 1, 0, 255, 0);
        chk("sat_pos", 64'(mem_wdata), 64'h7FFFFF);
        send(24'h800000, 1, 0, 0, 0);
        send(24'h800000, 1, 0, 255, 0);
        chk("sat_neg", 64'(mem_wdata), 64'h800000);
        for (int i = 0; i < 20; i++) send(24'($urandom), 1, 255, 8'($urandom), 8'($urandom));
        send(24'($urandom), 1, 7, 8'($urandom), 8'($urandom));
        send(24'($urandom), 1, 8, 8'($urandom), 8'($urandom));
        chk("overrun_clean", 64'(overrun), 0);
        @(negedge clk);
        mon_en = 0;
        chk("pre_abort_ready", 64'(in_ready), 1);
        d_in = 24'h123456; enable = 1; tm = 2; repeats = 64; mix = 32; in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
        @(posedge clk);
        #2 rst_n = 0;
        #1 chk("abort_outputs", 64'({in_ready, out_valid, d_out, overrun, mem_addr, mem_re, mem_we, mem_wdata}), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_we", 64'(mem_we), 0);
        end
        model_reset();
        @(posedge clk);
        #1 rst_n = 1;
        check_clear(1);
        chk("overrun_set", 64'(overrun), 1);
        chk("d_out_after_reset", 64'(d_out), 0);
        mon_en = 1;
        for (int i = 0; i < 6; i++) begin
            xv = 24'($urandom);
            send(xv, 0, 8'($urandom), 8'($urandom), 8'($urandom));
            chk("bypass", 64'(d_out), 64'(xv));
        end
        for (int i = 0; i < 6; i++) send(24'($urandom), 1, 1, 8'($urandom), 255);
        chk("overrun_sticky", 64'(overrun), 1);
        repeat (2) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
